// File: rtl/write_back_cache_pkg.sv
// Shared types and widths for the write-back cache.
// Holds the FSM state enum and the default line/word geometry.
package write_back_cache_pkg;

  localparam int unsigned AddrBits      = 32;
  localparam int unsigned WordBits      = 32;
  localparam int unsigned DefOffsetBits = 4;
  localparam int unsigned DefIndexBits  = 4;
  localparam int unsigned DefTagBits    =
    AddrBits - DefIndexBits - DefOffsetBits;
  localparam int unsigned DefNrWays     = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    RESP
  } state_e;

  function automatic int unsigned line_bits(
    input int unsigned offset_bits
  );
    return 8 * (1 << offset_bits);
  endfunction

endpackage

// File: rtl/write_back_cache.sv
// Set-associative write-back, write-allocate cache with LRU replacement.
// Ports: clk_i/rstn_i (sync, active-high); addr_i, read/write request
// and pulse responses toward the core; mem_* line fill / write-back.
module write_back_cache
  import write_back_cache_pkg::*;
#(
  parameter int unsigned ByteOffsetBits = DefOffsetBits,
  parameter int unsigned IndexBits      = DefIndexBits,
  parameter int unsigned TagBits        = DefTagBits,
  parameter int unsigned NrWays         = DefNrWays
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [31:0]                        addr_i,
  input  logic                               read_en_i,
  output logic                               read_valid_o,
  output logic [31:0]                        read_word_o,
  input  logic                               write_en_i,
  input  logic [31:0]                        write_word_i,
  output logic                               write_valid_o,
  output logic [31:0]                        mem_addr_o,
  output logic                               mem_read_en_o,
  input  logic                               mem_read_valid_i,
  input  logic [8*(2**ByteOffsetBits)-1:0]   mem_read_data_i,
  output logic                               mem_write_en_o,
  output logic [8*(2**ByteOffsetBits)-1:0]   mem_write_data_o,
  input  logic                               mem_write_valid_i
);

  localparam int unsigned LineBits = line_bits(ByteOffsetBits);
  localparam int unsigned Sets     = 1 << IndexBits;
  localparam int unsigned WordSel  = ByteOffsetBits - 2;
  localparam int unsigned WayW     =
    (NrWays > 1) ? $clog2(NrWays) : 1;

  logic [NrWays-1:0]   valid_q [Sets];
  logic [NrWays-1:0]   dirty_q [Sets];
  logic [TagBits-1:0]  tag_q   [Sets][NrWays];
  logic [LineBits-1:0] data_q  [Sets][NrWays];
  logic [WayW-1:0]     age_q   [Sets][NrWays];

  state_e            state_q, state_d;
  logic [WayW-1:0]   victim_q;
  logic              op_read_q;
  logic [WordBits-1:0] rdata_q;

  logic [TagBits-1:0]   req_tag;
  logic [IndexBits-1:0] req_idx;
  logic [WordSel-1:0]   req_word;
  logic                 req;
  logic                 unused_addr;

  assign req_tag  = addr_i[31 -: TagBits];
  assign req_idx  = addr_i[ByteOffsetBits +: IndexBits];
  assign req_word = addr_i[2 +: WordSel];
  assign req      = read_en_i | write_en_i;
  assign unused_addr = ^addr_i[1:0];

  logic            hit;
  logic [WayW-1:0] hit_way;
  logic            inv_found;
  logic [WayW-1:0] inv_way;
  logic [WayW-1:0] lru_way;
  logic [WayW-1:0] victim_way;
  logic            victim_dirty;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < NrWays; w++) begin
      if (valid_q[req_idx][w] &&
          tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
      if (age_q[req_idx][w] == WayW'(NrWays - 1))
        lru_way = WayW'(w);
    end
    // Scan downward so the lowest invalid way wins.
    for (int w = NrWays - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WayW'(w);
      end
    end
    victim_way   = inv_found ? inv_way : lru_way;
    victim_dirty = valid_q[req_idx][victim_way] &
                   dirty_q[req_idx][victim_way];
  end

  always_comb begin
    state_d          = state_q;
    read_valid_o     = 1'b0;
    read_word_o      = '0;
    write_valid_o    = 1'b0;
    mem_addr_o       = '0;
    mem_read_en_o    = 1'b0;
    mem_write_en_o   = 1'b0;
    mem_write_data_o = '0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit)               state_d = RESP;
          else if (victim_dirty) state_d = WRITEBACK;
          else                   state_d = REFILL;
        end
      end
      WRITEBACK: begin
        mem_write_en_o   = 1'b1;
        mem_addr_o       = {tag_q[req_idx][victim_q], req_idx,
                            {ByteOffsetBits{1'b0}}};
        mem_write_data_o = data_q[req_idx][victim_q];
        if (mem_write_valid_i) state_d = REFILL;
      end
      REFILL: begin
        mem_read_en_o = 1'b1;
        mem_addr_o    = {req_tag, req_idx,
                         {ByteOffsetBits{1'b0}}};
        if (mem_read_valid_i) state_d = IDLE;
      end
      RESP: begin
        read_valid_o  = op_read_q;
        write_valid_o = !op_read_q;
        read_word_o   = op_read_q ? rdata_q : '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A hit or a completed fill makes that way MRU.
  logic            touch_en;
  logic [WayW-1:0] touch_way;

  always_comb begin
    touch_en  = 1'b0;
    touch_way = hit_way;
    if (state_q == IDLE && req && hit) begin
      touch_en = 1'b1;
    end else if (state_q == REFILL && mem_read_valid_i) begin
      touch_en  = 1'b1;
      touch_way = victim_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      state_q   <= IDLE;
      victim_q  <= '0;
      op_read_q <= 1'b0;
      rdata_q   <= '0;
      for (int s = 0; s < Sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NrWays; w++)
          age_q[s][w] <= WayW'(w);
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        op_read_q <= read_en_i;
        if (!hit) begin
          victim_q <= victim_way;
        end else if (read_en_i) begin
          rdata_q <= data_q[req_idx][hit_way]
                       [req_word*WordBits +: WordBits];
        end else begin
          data_q[req_idx][hit_way]
            [req_word*WordBits +: WordBits] <= write_word_i;
          dirty_q[req_idx][hit_way] <= 1'b1;
        end
      end
      if (state_q == REFILL && mem_read_valid_i) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
        tag_q[req_idx][victim_q]   <= req_tag;
        data_q[req_idx][victim_q]  <= mem_read_data_i;
      end
      if (touch_en) begin
        for (int w = 0; w < NrWays; w++) begin
          if (WayW'(w) == touch_way)
            age_q[req_idx][w] <= '0;
          else if (age_q[req_idx][w] <
                   age_q[req_idx][touch_way])
            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_write_back_cache.sv
// Self-checking bench for write_back_cache: line-level LRU model,
// DRAM responder, per-cycle compare process and directed accesses.
module tb_write_back_cache;

  localparam int Lat = 4;

  logic         clk;
  logic         rstn_i;
  logic [31:0]  addr_i;
  logic         read_en_i;
  logic         read_valid_o;
  logic [31:0]  read_word_o;
  logic         write_en_i;
  logic [31:0]  write_word_i;
  logic         write_valid_o;
  logic [31:0]  mem_addr_o;
  logic         mem_read_en_o;
  logic         mem_read_valid_i;
  logic [127:0] mem_read_data_i;
  logic         mem_write_en_o;
  logic [127:0] mem_write_data_o;
  logic         mem_write_valid_i;

  write_back_cache dut (
    .clk_i             (clk),
    .rstn_i            (rstn_i),
    .addr_i            (addr_i),
    .read_en_i         (read_en_i),
    .read_valid_o      (read_valid_o),
    .read_word_o       (read_word_o),
    .write_en_i        (write_en_i),
    .write_word_i      (write_word_i),
    .write_valid_o     (write_valid_o),
    .mem_addr_o        (mem_addr_o),
    .mem_read_en_o     (mem_read_en_o),
    .mem_read_valid_i  (mem_read_valid_i),
    .mem_read_data_i   (mem_read_data_i),
    .mem_write_en_o    (mem_write_en_o),
    .mem_write_data_o  (mem_write_data_o),
    .mem_write_valid_i (mem_write_valid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [31:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++)
      l[w*32 +: 32] = 32'h5A00_0000 + la + 32'(w * 4);
    return l;
  endfunction

  // Bench DRAM (what the DUT actually wrote back)
  logic [127:0] dram [logic [31:0]];

  function automatic logic [127:0] dram_get(input logic [31:0] la);
    if (dram.exists(la)) return dram[la];
    return init_line(la);
  endfunction

  int rd_cnt = 0;
  int wr_cnt = 0;
  initial begin
    mem_read_valid_i  = 1'b0;
    mem_write_valid_i = 1'b0;
    mem_read_data_i   = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_read_valid_i  = 1'b0;
      mem_write_valid_i = 1'b0;
      mem_read_data_i   = '0;
      if (mem_read_en_o) begin
        rd_cnt++;
        if (rd_cnt == Lat) begin
          mem_read_valid_i = 1'b1;
          mem_read_data_i  = dram_get(mem_addr_o);
          rd_cnt = 0;
        end
      end else rd_cnt = 0;
      if (mem_write_en_o) begin
        wr_cnt++;
        if (wr_cnt == Lat) begin
          mem_write_valid_i = 1'b1;
          dram[mem_addr_o]  = mem_write_data_o;
          wr_cnt = 0;
        end
      end else wr_cnt = 0;
    end
  end

  // Reference model: per set, resident lines ordered MRU first.
  typedef struct packed {
    logic [23:0]  tag;
    logic         dirty;
    logic [127:0] data;
  } mline_t;

  mline_t       mset [16][$];
  logic [127:0] ref_mem [logic [31:0]];

  logic         exp_hit, exp_read, exp_wb;
  logic [31:0]  exp_wb_addr, exp_refill_addr, exp_word;
  logic [127:0] exp_wb_data;

  task automatic predict(input logic rd, input logic [31:0] a,
                         input logic [31:0] wd);
    logic [3:0]  idx;
    logic [31:0] la;
    int          pos;
    int          wi;
    mline_t      ln;
    mline_t      v;
    idx = a[7:4];
    la  = {a[31:4], 4'h0};
    wi  = int'(a[3:2]);
    pos = -1;
    for (int i = 0; i < mset[idx].size(); i++)
      if (mset[idx][i].tag == a[31:8]) pos = i;
    exp_wb   = 1'b0;
    exp_hit  = (pos >= 0);
    exp_read = rd;
    if (pos >= 0) begin
      ln = mset[idx][pos];
      mset[idx].delete(pos);
    end else begin
      if (mset[idx].size() == 4) begin
        v = mset[idx].pop_back();
        if (v.dirty) begin
          exp_wb      = 1'b1;
          exp_wb_addr = {v.tag, idx, 4'h0};
          exp_wb_data = v.data;
          ref_mem[exp_wb_addr] = v.data;
        end
      end
      ln.tag   = a[31:8];
      ln.dirty = 1'b0;
      ln.data  = ref_mem.exists(la) ? ref_mem[la] : init_line(la);
      exp_refill_addr = la;
    end
    if (rd) exp_word = ln.data[wi*32 +: 32];
    else begin
      ln.data[wi*32 +: 32] = wd;
      ln.dirty = 1'b1;
    end
    mset[idx].push_front(ln);
  endtask

  logic         chk_en = 1'b0;
  logic         req_active = 1'b0;
  logic         resp_seen, saw_wb, saw_refill;
  logic [31:0]  got_word, last_refill_addr, last_wb_addr;
  logic [127:0] last_wb_data;

  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_read_en_o && mem_write_en_o)
        check("mem_en_exclusive", 1'b1, 1'b0);
      if (!mem_read_en_o && !mem_write_en_o)
        check("mem_addr_idle", mem_addr_o, 32'h0);
      if (mem_write_en_o) begin
        saw_wb       = 1'b1;
        last_wb_addr = mem_addr_o;
        last_wb_data = mem_write_data_o;
        check("wb_addr", mem_addr_o, exp_wb_addr);
        check("wb_data", mem_write_data_o, exp_wb_data);
      end
      if (mem_read_en_o) begin
        saw_refill       = 1'b1;
        last_refill_addr = mem_addr_o;
        check("refill_addr", mem_addr_o, exp_refill_addr);
      end
      if (read_valid_o || write_valid_o) begin
        check("resp_expected", req_active && !resp_seen, 1'b1);
        check("resp_kind", read_valid_o, exp_read);
        check("resp_excl", read_valid_o & write_valid_o, 1'b0);
        if (read_valid_o) begin
          got_word = read_word_o;
          check("read_word", read_word_o, exp_word);
        end
        resp_seen = 1'b1;
      end
    end
  end

  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a,
                        input logic [31:0] wd);
    int lat;
    @(posedge clk);
    #1;
    predict(rd, a, wd);
    saw_wb = 1'b0; saw_refill = 1'b0; resp_seen = 1'b0;
    got_word = '0; last_refill_addr = '0;
    last_wb_addr = '0; last_wb_data = '0;
    req_active   = 1'b1;
    addr_i       = a;
    write_word_i = wd;
    read_en_i    = rd;
    write_en_i   = wr;
    lat = 0;
    while (!resp_seen && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
    end
    read_en_i  = 1'b0;
    write_en_i = 1'b0;
    req_active = 1'b0;
    check("resp_arrived", resp_seen, 1'b1);
    check("wb_traffic", saw_wb, exp_wb);
    check("refill_traffic", saw_refill, !exp_hit);
    if (exp_hit) check("hit_latency", lat, 1);
  endtask

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;

  vec_t tbl [8] = '{
    '{1'b0, 1'b1, 32'h020, 32'h2222_0020},
    '{1'b1, 1'b0, 32'h124, 32'h0},
    '{1'b0, 1'b1, 32'h228, 32'h2222_0228},
    '{1'b1, 1'b0, 32'h32C, 32'h0},
    '{1'b1, 1'b0, 32'h020, 32'h0},
    '{1'b1, 1'b0, 32'h420, 32'h0},
    '{1'b0, 1'b1, 32'h524, 32'h2222_0524},
    '{1'b1, 1'b0, 32'h228, 32'h0}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rstn_i = 1'b1; addr_i = '0; read_en_i = 1'b0;
    write_en_i = 1'b0; write_word_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_valid", read_valid_o, 1'b0);
    check("rst_write_valid", write_valid_o, 1'b0);
    check("rst_read_word", read_word_o, 32'h0);
    check("rst_mem_rd_en", mem_read_en_o, 1'b0);
    check("rst_mem_wr_en", mem_write_en_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    rstn_i = 1'b0;
    chk_en = 1'b1;

    access(1'b0, 1'b1, 32'h010, 32'hDEAD_BEEF);
    check("w010_refill_lit", last_refill_addr, 32'h010);
    access(1'b1, 1'b0, 32'h114, 32'h0);
    check("r114_refill_lit", last_refill_addr, 32'h110);
    check("r114_word_lit", got_word, 32'h5A00_0114);
    access(1'b0, 1'b1, 32'h018, 32'hABCD_ABCD);
    check("w018_no_refill_lit", saw_refill, 1'b0);
    access(1'b1, 1'b1, 32'h018, 32'h1111_1111);
    check("rw018_read_prio_lit", got_word, 32'hABCD_ABCD);
    access(1'b1, 1'b0, 32'h018, 32'h0);
    check("r018_word_lit", got_word, 32'hABCD_ABCD);

    access(1'b1, 1'b0, 32'h010, 32'h0);
    access(1'b1, 1'b0, 32'h110, 32'h0);
    access(1'b1, 1'b0, 32'h210, 32'h0);
    access(1'b1, 1'b0, 32'h310, 32'h0);
    access(1'b0, 1'b1, 32'h414, 32'h7777_0414);
    check("evict_wb_addr_lit", last_wb_addr, 32'h010);
    check("evict_wb_w0_lit", last_wb_data[31:0], 32'hDEAD_BEEF);
    check("evict_wb_w2_lit", last_wb_data[95:64], 32'hABCD_ABCD);
    check("evict_refill_lit", last_refill_addr, 32'h410);
    access(1'b1, 1'b0, 32'h010, 32'h0);
    check("reread_010_lit", got_word, 32'hDEAD_BEEF);

    foreach (tbl[i]) access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);

    // Abort a fill with reset; dirty line 0x410 is discarded.
    @(posedge clk);
    #1;
    predict(1'b1, 32'h810, 32'h0);
    req_active = 1'b1;
    resp_seen  = 1'b0;
    addr_i     = 32'h810;
    read_en_i  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = mem_read_en_o;
    end
    check("abort_refill_seen", seen, 1'b1);
    check("abort_refill_addr", mem_addr_o, 32'h810);
    rstn_i     = 1'b1;
    read_en_i  = 1'b0;
    req_active = 1'b0;
    @(posedge clk);
    #1;
    check("abort_mem_rd_en", mem_read_en_o, 1'b0);
    check("abort_mem_wr_en", mem_write_en_o, 1'b0);
    check("abort_mem_addr", mem_addr_o, 32'h0);
    rstn_i = 1'b0;
    for (int s = 0; s < 16; s++) mset[s].delete();

    access(1'b1, 1'b0, 32'h414, 32'h0);
    check("post_rst_414_lit", got_word, 32'h5A00_0414);
    access(1'b1, 1'b0, 32'h018, 32'h0);
    check("post_rst_018_lit", got_word, 32'hABCD_ABCD);
    check("post_rst_018_miss", last_refill_addr, 32'h010);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
